// File: rtl/store_merge_unit.sv
// Store-side narrowing unit: packs byte/halfword/word stores into a word-organised
// data RAM, using read-modify-write so that untouched byte lanes are preserved.
module store_merge_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t            state_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [ADDR_W-3:0] addr_q;
    logic [15:0]       sdata_q;
    logic [31:0]       wdata_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic              done_q;
    logic              err_q;

    logic              misaligned_s;
    logic [31:0]       merged_d;

    // Halfwords need an even offset, words a zero offset; size 3 is never legal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian lane replacement; bits of data above the store size are dropped.
    function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                                input logic [15:0] data,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: res[{off, 3'b000} +: 8] = data[7:0];
            SZ_HALF: begin
                if (off[1]) begin
                    res[31:16] = data;
                end else begin
                    res[15:0] = data;
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Acceptance-time alignment decode and merge of the returned memory word.
    always_comb begin
        misaligned_s = is_misaligned(req_size, req_addr[1:0]);
        merged_d     = merge_lanes(mem_rdata, sdata_q, size_q, off_q);
    end

    // Control FSM; strobes are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            size_q   <= 2'd0;
            off_q    <= 2'd0;
            addr_q   <= '0;
            sdata_q  <= 16'd0;
            wdata_q  <= 32'd0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        size_q  <= req_size;
                        off_q   <= req_addr[1:0];
                        addr_q  <= req_addr[ADDR_W-1:2];
                        sdata_q <= req_data[15:0];
                        if (misaligned_s) begin
                            state_q <= ST_ERROR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (req_size == SZ_WORD) begin
                            state_q  <= ST_WRITE;
                            wdata_q  <= req_data;
                            mem_we_q <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            state_q  <= ST_READ;
                            mem_re_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    // RAM output becomes valid during MERGE.
                    state_q <= ST_MERGE;
                end
                ST_MERGE: begin
                    state_q  <= ST_WRITE;
                    wdata_q  <= merged_d;
                    mem_we_q <= 1'b1;
                    done_q   <= 1'b1;
                end
                ST_WRITE: state_q <= ST_IDLE;
                ST_ERROR: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_addr  = addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
